// File: rtl/alu_execute_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_execute_if
//  Description : Operand/control bundle from the execute preprocessor into the
//                execute-stage ALU, plus the ALU result/flag/handshake returns.
//                master : upstream stage (drives operands and enables)
//                slave  : alu_execute (drives result, flags, valid_out, busy)
//  Signals     : enable_arith, enable_shift, aluin1, aluin2, operation,
//                opselect, shift_number  (master -> slave)
//                aluout, carry, overflow, valid_out, busy  (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_execute_if #(
    parameter int WIDTH = 32
);
    logic             enable_arith;
    logic             enable_shift;
    logic [WIDTH-1:0] aluin1;
    logic [WIDTH-1:0] aluin2;
    logic [2:0]       operation;
    logic [2:0]       opselect;
    logic [4:0]       shift_number;
    logic [WIDTH-1:0] aluout;
    logic             carry;
    logic             overflow;
    logic             valid_out;
    logic             busy;

    modport master (
        output enable_arith, enable_shift, aluin1, aluin2,
               operation, opselect, shift_number,
        input  aluout, carry, overflow, valid_out, busy
    );

    modport slave (
        input  enable_arith, enable_shift, aluin1, aluin2,
               operation, opselect, shift_number,
        output aluout, carry, overflow, valid_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_execute.sv
`default_nettype none
// ============================================================================
//  Module      : alu_execute
//  Description : Execute-stage ALU. Arithmetic, logic and memory-read
//                pass-through complete in one cycle. Shifts are either a
//                single-cycle barrel shift (default) or an iterative
//                one-bit-per-cycle shifter with a busy stall when the macro
//                ALU_SERIAL_SHIFT_EN is defined. Results are identical in
//                both builds; only shift latency and busy differ.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-low reset
//                bus    - alu_execute_if.slave (operands, enables, result,
//                         carry, overflow, valid_out, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_execute #(
    parameter int WIDTH = 32
) (
    input wire           clock,
    input wire           reset,
    alu_execute_if.slave bus
);

    localparam logic [2:0] OPSEL_SHIFT = 3'b000;
    localparam logic [2:0] OPSEL_ARITH = 3'b001;
    localparam logic [2:0] OPSEL_MEMRD = 3'b101;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_HADD = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LHG  = 3'b111;

    logic             arith_req;
    logic             shift_req;
    logic             arith_accept;
    logic             shift_done;
    logic [WIDTH-1:0] shift_value;
    logic             busy_flag;

    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             overflow_flag;
    logic             valid_pulse;

    // Arith wins a collision, so a shift is only a request when arith is idle.
    assign arith_req = bus.enable_arith &&
                       ((bus.opselect == OPSEL_ARITH) || (bus.opselect == OPSEL_MEMRD));
    assign shift_req = bus.enable_shift && !bus.enable_arith &&
                       (bus.opselect == OPSEL_SHIFT);

    // ------------------------------------------------------------------
    // Arithmetic / logic / memory-read datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [16:0]      half_sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] arith_res;
    logic             arith_carry;
    logic             arith_ovf;

    always_comb begin
        sum_ext     = {1'b0, bus.aluin1} + {1'b0, bus.aluin2};
        half_sum    = {1'b0, bus.aluin1[15:0]} + {1'b0, bus.aluin2[15:0]};
        diff        = bus.aluin1 - bus.aluin2;
        arith_res   = '0;
        arith_carry = 1'b0;
        arith_ovf   = 1'b0;
        if (bus.opselect == OPSEL_MEMRD) begin
            arith_res = bus.aluin2;
        end else begin
            case (bus.operation)
                OP_ADD: begin
                    arith_res   = sum_ext[WIDTH-1:0];
                    arith_carry = sum_ext[WIDTH];
                    // Like-signed operands producing an opposite-signed sum.
                    arith_ovf   = (bus.aluin1[WIDTH-1] == bus.aluin2[WIDTH-1]) &&
                                  (sum_ext[WIDTH-1] != bus.aluin1[WIDTH-1]);
                end
                OP_HADD: begin
                    arith_res   = {{(WIDTH-16){half_sum[15]}}, half_sum[15:0]};
                    arith_carry = half_sum[16];
                    arith_ovf   = (bus.aluin1[15] == bus.aluin2[15]) &&
                                  (half_sum[15] != bus.aluin1[15]);
                end
                OP_SUB: begin
                    arith_res   = diff;
                    arith_carry = (bus.aluin1 < bus.aluin2);
                    // Differently-signed operands where the result takes B's sign.
                    arith_ovf   = (bus.aluin1[WIDTH-1] != bus.aluin2[WIDTH-1]) &&
                                  (diff[WIDTH-1] != bus.aluin1[WIDTH-1]);
                end
                OP_NOT:  arith_res = ~bus.aluin2;
                OP_AND:  arith_res = bus.aluin1 & bus.aluin2;
                OP_OR:   arith_res = bus.aluin1 | bus.aluin2;
                OP_XOR:  arith_res = bus.aluin1 ^ bus.aluin2;
                OP_LHG:  arith_res = {bus.aluin2[15:0], {(WIDTH-16){1'b0}}};
                default: arith_res = '0;
            endcase
        end
    end

`ifdef ALU_SERIAL_SHIFT_EN
    // ------------------------------------------------------------------
    // Iterative shifter: one bit per cycle, busy while in SHIFT
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [4:0]       count;
    logic [2:0]       mode;
    logic [WIDTH-1:0] shift_step;

    always_comb begin
        shift_step = shift_reg;
        case (mode)
            3'b000, 3'b001: shift_step = {shift_reg[WIDTH-2:0], 1'b0};
            3'b010:         shift_step = {1'b0, shift_reg[WIDTH-1:1]};
            3'b011:         shift_step = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
            default:        shift_step = shift_reg;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (shift_req && (bus.shift_number != 5'd0)) next_state = SHIFT;
            SHIFT:   if (count == 5'd1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= 5'd0;
            mode      <= 3'b000;
            busy_flag <= 1'b0;
        end else begin
            state     <= next_state;
            busy_flag <= (next_state == SHIFT);
            if (state == IDLE) begin
                if (shift_req && (bus.shift_number != 5'd0)) begin
                    shift_reg <= bus.aluin1;
                    count     <= bus.shift_number;
                    mode      <= bus.operation;
                end
            end else begin
                shift_reg <= shift_step;
                count     <= count - 5'd1;
            end
        end
    end

    // All enables are ignored while a serial shift is in flight.
    assign arith_accept = arith_req && (state == IDLE);
    assign shift_done   = ((state == IDLE) && shift_req && (bus.shift_number == 5'd0)) ||
                          ((state == SHIFT) && (count == 5'd1));
    assign shift_value  = (state == SHIFT) ? shift_step : bus.aluin1;
`else
    // ------------------------------------------------------------------
    // Single-cycle barrel shifter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] barrel;

    always_comb begin
        barrel = bus.aluin1;
        case (bus.operation)
            3'b000, 3'b001: barrel = bus.aluin1 << bus.shift_number;
            3'b010:         barrel = bus.aluin1 >> bus.shift_number;
            3'b011:         barrel = $unsigned($signed(bus.aluin1) >>> bus.shift_number);
            default:        barrel = bus.aluin1;
        endcase
    end

    assign arith_accept = arith_req;
    assign shift_done   = shift_req;
    assign shift_value  = barrel;
    assign busy_flag    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Result / flag register. Shifts leave carry and overflow untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result        <= '0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            valid_pulse   <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            if (arith_accept) begin
                result        <= arith_res;
                carry_flag    <= arith_carry;
                overflow_flag <= arith_ovf;
                valid_pulse   <= 1'b1;
            end else if (shift_done) begin
                result      <= shift_value;
                valid_pulse <= 1'b1;
            end
        end
    end

    assign bus.aluout    = result;
    assign bus.carry     = carry_flag;
    assign bus.overflow  = overflow_flag;
    assign bus.valid_out = valid_pulse;
    assign bus.busy      = busy_flag;

endmodule
`default_nettype wire

// File: tb/tb_alu_execute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_execute
//  Description : Self-checking bench for alu_execute. Expected results are
//                queued when a request is driven and popped when valid_out
//                is observed. Adapts shift latency/busy expectations to the
//                ALU_SERIAL_SHIFT_EN build option.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_execute;

`ifdef ALU_SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];
    logic m_c = 1'b0;
    logic m_v = 1'b0;

    always #5 clock = ~clock;

    alu_execute_if #(.WIDTH(32)) bus ();

    alu_execute #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic exp_t model_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] u;
        logic [16:0] hu;
        longint      s;
        int          h;
        e = '0;
        case (op)
            3'b000: begin
                u = {1'b0, a} + {1'b0, b};
                e.res = u[31:0];
                e.c = u[32];
                s = longint'($signed(a)) + longint'($signed(b));
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b001: begin
                hu = {1'b0, a[15:0]} + {1'b0, b[15:0]};
                e.res = {{16{hu[15]}}, hu[15:0]};
                e.c = hu[16];
                h = int'($signed(a[15:0])) + int'($signed(b[15:0]));
                e.v = (h > 32767) || (h < -32768);
            end
            3'b010: begin
                e.res = a - b;
                e.c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b011: e.res = ~b;
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = a ^ b;
            default: e.res = {b[15:0], 16'h0000};
        endcase
        return e;
    endfunction

    function automatic logic [31:0] model_shift(input logic [2:0] op, input logic [31:0] a, input logic [4:0] n);
        logic signed [31:0] t;
        t = a;
        case (op)
            3'b000, 3'b001: return a << n;
            3'b010:         return a >> n;
            3'b011:         return t >>> n;
            default:        return a;
        endcase
    endfunction

    function automatic exp_t pop_exp();
        if (sb.size() == 0) return '0;
        return sb.pop_front();
    endfunction

    // Drive one request for one cycle, queue its expectation if it is accepted.
    task automatic drive_op(input bit ar, input bit sh, input logic [2:0] opsel, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] n);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        e   = '0;
        bus.enable_arith = ar;
        bus.enable_shift = sh;
        bus.opselect     = opsel;
        bus.operation    = op;
        bus.aluin1       = a;
        bus.aluin2       = b;
        bus.shift_number = n;
        if (ar && opsel == 3'b001) begin
            e = model_arith(op, a, b);
            acc = 1'b1;
        end else if (ar && opsel == 3'b101) begin
            e.res = b;
            acc = 1'b1;
        end else if (!ar && sh && opsel == 3'b000) begin
            e.res = model_shift(op, a, n);
            e.c = m_c;
            e.v = m_v;
            acc = 1'b1;
        end
        if (acc) begin
            sb.push_back(e);
            m_c = e.c;
            m_v = e.v;
        end
        @(negedge clock);
        bus.enable_arith = 1'b0;
        bus.enable_shift = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clock);
        vectors++;
        if ({bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy} !== 36'h0) begin
            errors++;
            $display("FAIL reset_init: out=%h c=%b v=%b valid=%b busy=%b, want all 0",
                     bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy);
        end
        reset = 1'b1;
        drive_op(1, 0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        drive_op(1, 0, 3'b001, 3'b110, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy} !== 36'h0) begin
            errors++;
            $display("FAIL reset_async: out=%h c=%b v=%b valid=%b busy=%b, want all 0",
                     bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy);
        end
        sb.delete();
        m_c = 1'b0;
        m_v = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (bus.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle%0d: valid=%b, want 0", i, bus.valid_out);
            end
        end
    endtask

    task automatic test_add();
        exp_t e, got;
        drive_op(1, 0, 3'b001, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e || got !== {32'h8000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add: valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                     bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
        end
        @(negedge clock);
        vectors++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL add_pulse: valid=%b, want 0", bus.valid_out);
        end
    endtask

    task automatic test_sub_hadd();
        exp_t e, got;
        drive_op(1, 0, 3'b001, 3'b010, 32'd5, 32'd7, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e || got !== {32'hFFFF_FFFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub: valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                     bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
        end
        drive_op(1, 0, 3'b001, 3'b001, 32'h0000_FFFF, 32'h0000_0001, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e || got !== {32'h0000_0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hadd: valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                     bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
        end
    endtask

    task automatic test_shift();
        exp_t        e, got;
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  n;
        int          lat, bcnt, want_lat, want_busy;
        // Leave overflow set so "flags unchanged" is observable.
        drive_op(1, 0, 3'b001, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        e = pop_exp();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       begin op = 3'b011; a = 32'h8000_0000; n = 5'd4; end
                1:       begin op = 3'b010; a = $urandom; n = 5'd0; end
                2:       begin op = 3'b011; a = 32'h9000_0001; n = 5'd31; end
                3:       begin op = 3'b000; a = 32'h0000_0003; n = 5'd31; end
                default: begin op = 3'($urandom_range(0, 7)); a = $urandom; n = 5'($urandom_range(1, 12)); end
            endcase
            drive_op(0, 1, 3'b000, op, a, 32'h5555_5555, n);
            lat  = 0;
            bcnt = 0;
            while (bus.valid_out !== 1'b1 && lat < 40) begin
                if (bus.busy === 1'b1) bcnt++;
                if (SERIAL && i == 0 && lat == 0) begin
                    bus.enable_arith = 1'b1;
                    bus.enable_shift = 1'b1;
                    bus.opselect     = 3'b001;
                    bus.operation    = 3'b000;
                    bus.aluin1       = 32'h1;
                    bus.aluin2       = 32'h1;
                end
                @(negedge clock);
                bus.enable_arith = 1'b0;
                bus.enable_shift = 1'b0;
                lat++;
            end
            want_lat  = (SERIAL && n != 5'd0) ? int'(n) : 0;
            want_busy = want_lat;
            e = pop_exp();
            got = {bus.aluout, bus.carry, bus.overflow};
            vectors++;
            if (bus.valid_out !== 1'b1 || got !== e || lat != want_lat || bcnt != want_busy || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL shift%0d: op=%b n=%0d valid=%b out=%h c=%b v=%b lat=%0d busycyc=%0d busy=%b, want out=%h c=%b v=%b lat=%0d busycyc=%0d busy=0",
                         i, op, n, bus.valid_out, got.res, got.c, got.v, lat, bcnt, bus.busy,
                         e.res, e.c, e.v, want_lat, want_busy);
            end
            if (i == 0) begin
                vectors++;
                if (got !== {32'hF800_0000, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL sra_const: out=%h c=%b v=%b, want F8000000 c=0 v=1", got.res, got.c, got.v);
                end
                @(negedge clock);
                vectors++;
                if (bus.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_stall: valid=%b after completion, want 0", bus.valid_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        exp_t e, got;
        drive_op(0, 1, 3'b000, 3'b010, 32'hFFFF_0000, 32'h0, 5'd20);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_shift: out=%h c=%b v=%b valid=%b busy=%b, want all 0",
                     bus.aluout, bus.carry, bus.overflow, bus.valid_out, bus.busy);
        end
        sb.delete();
        m_c = 1'b0;
        m_v = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        drive_op(0, 1, 3'b000, 3'b000, 32'h0000_1234, 32'h0, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || bus.busy !== 1'b0 || got !== e || got !== {32'h0000_1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL shift_after_reset: valid=%b busy=%b out=%h c=%b v=%b, want valid=1 busy=0 out=%h c=%b v=%b",
                     bus.valid_out, bus.busy, got.res, got.c, got.v, e.res, e.c, e.v);
        end
    endtask

    task automatic test_memread_collision();
        exp_t e, got;
        drive_op(1, 0, 3'b001, 3'b010, 32'd1, 32'd2, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL pre_sub: out=%h c=%b v=%b, want %h c=%b v=%b", got.res, got.c, got.v, e.res, e.c, e.v);
        end
        drive_op(1, 0, 3'b101, 3'b010, 32'h1111_1111, 32'hDEAD_BEEF, 5'd0);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e || got !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL memread: valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                     bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
        end
        drive_op(1, 1, 3'b001, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4);
        e = pop_exp();
        got = {bus.aluout, bus.carry, bus.overflow};
        vectors++;
        if (bus.valid_out !== 1'b1 || got !== e || got !== {32'hF000_F000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL collision: valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                     bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
        end
        drive_op(1, 0, 3'b010, 3'b000, 32'h1, 32'h1, 5'd0);
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 || bus.aluout !== 32'hF000_F000) begin
            errors++;
            $display("FAIL bad_opselect: valid=%b busy=%b out=%h, want valid=0 busy=0 out=f000f000",
                     bus.valid_out, bus.busy, bus.aluout);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e, got;
        logic [2:0] op, opsel;
        for (int i = 0; i < 16; i++) begin
            op    = 3'(i % 8);
            opsel = (i == 11) ? 3'b101 : 3'b001;
            drive_op(1, 0, opsel, op, $urandom, $urandom, 5'd0);
            e = pop_exp();
            got = {bus.aluout, bus.carry, bus.overflow};
            vectors++;
            if (bus.valid_out !== 1'b1 || got !== e) begin
                errors++;
                $display("FAIL b2b%0d: opsel=%b op=%b valid=%b out=%h c=%b v=%b, want valid=1 out=%h c=%b v=%b",
                         i, opsel, op, bus.valid_out, got.res, got.c, got.v, e.res, e.c, e.v);
            end
        end
        @(negedge clock);
        vectors++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, want 0", bus.valid_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable_arith = 1'b0;
        bus.enable_shift = 1'b0;
        bus.aluin1       = '0;
        bus.aluin2       = '0;
        bus.operation    = '0;
        bus.opselect     = '0;
        bus.shift_number = '0;
        test_reset();
        test_add();
        test_sub_hadd();
        test_shift();
        test_reset_mid_shift();
        test_memread_collision();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_execute.md
# alu_execute

Execute-stage ALU that directly consumes the operand/control bundle registered by the execute preprocessor: aluin1, aluin2, operation, opselect, shift_number, enable_arith and enable_shift. It produces a registered 32-bit result with a one-cycle valid pulse, plus carry and overflow flags. Arithmetic and logic operations take one cycle. Shifts are either single-cycle or iterative (one bit per cycle with a busy stall), selected at compile time.

## Interface
- WIDTH, 32, datapath width; all encodings and flag rules below assume 32.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable_arith  in  1  arithmetic/logic/pass-through request, sampled on the clock edge.
- enable_shift  in  1  shift request, sampled on the clock edge.
- aluin1  in  WIDTH  signed operand A (shift source).
- aluin2  in  WIDTH  signed operand B (register, immediate or memory data).
- operation  in  3  operation code.
- opselect  in  3  class: 001 arith/logic, 101 memory read, 000 shift.
- shift_number  in  5  shift amount, 0–31.
- aluout  out  WIDTH  registered result.
- carry  out  1  registered carry/borrow flag.
- overflow  out  1  registered signed-overflow flag.
- valid_out  out  1  one-cycle pulse when aluout updates.
- busy  out  1  shift in progress; upstream must not issue while high.

## Operation
- Arith, accepted when enable_arith=1 and opselect=001. Results by operation code:
  - 000 ADD: {carry,aluout}=aluin1+aluin2, 33-bit unsigned sum; overflow set on signed overflow.
  - 001 HADD: 16-bit add of aluin1[15:0] and aluin2[15:0]; result sign-extended from bit 15; carry=carry out of bit 15; overflow=16-bit signed overflow.
  - 010 SUB: aluout=aluin1−aluin2; carry=1 iff aluin1<aluin2 unsigned (borrow); overflow on signed overflow.
  - 011 NOT: ~aluin2.
  - 100 AND, 101 OR, 110 XOR: bitwise aluin1 op aluin2.
  - 111 LHG: {aluin2[15:0],16'h0}.
- Flags for NOT, AND, OR, XOR and LHG: carry=0, overflow=0.
- Memory read (enable_arith=1, opselect=101): aluout=aluin2 regardless of operation; carry=0, overflow=0.
- enable_arith with any other opselect: ignored; no valid_out pulse.
- Shift (enable_shift=1, opselect=000), by operation code:
  - 000 and 001: shift left logical. Arithmetic left equals logical left.
  - 010: shift right logical.
  - 011: shift right arithmetic, replicating bit 31.
  - 1xx: result = aluin1 unshifted.
- Shifts never modify carry or overflow.
- Outputs hold their value when no operation completes.
- If enable_arith and enable_shift are both high in the same cycle, arith is taken and the shift is dropped.
- Serial-shift state machine: IDLE and SHIFT.
  - IDLE: a shift with shift_number=0 completes the next edge (aluout=aluin1, valid_out=1) and stays in IDLE.
  - IDLE: a shift with shift_number≠0 loads the internal shift register from aluin1, loads the counter with shift_number and the mode from operation, then moves to SHIFT.
  - SHIFT: each edge shifts one bit and decrements the counter. On the edge where the counter goes 1→0, aluout is written, valid_out pulses and the state returns to IDLE.
  - All enables are ignored in SHIFT. aluout keeps its old value until completion.

## Timing
- Reset (asynchronous, reset=0): aluout=0, carry=0, overflow=0, valid_out=0, busy=0, state=IDLE, counter=0. This takes effect immediately, including mid-shift; the in-flight shift is discarded.
- Arith and memory read: result, flags and valid_out appear one edge after the request is sampled.
- valid_out is high for exactly one cycle per completed operation. It can be high in back-to-back cycles for consecutive arith requests.
- Serial shift: latency is shift_number edges (1 when shift_number=0).
  - busy is registered and high while state=SHIFT, i.e. for shift_number cycles, starting the cycle after acceptance.
  - busy falls in the same cycle valid_out rises.
  - A new request is accepted on the edge that ends the cycle valid_out is high.

## Configuration
- ALU_SERIAL_SHIFT_EN defined: iterative shifter and IDLE/SHIFT state machine as described; busy is functional.
- ALU_SERIAL_SHIFT_EN undefined: single-cycle barrel shift with the same latency as arith.
  - busy is tied to 0.
  - No state machine or counter is built.
  - Results are bit-identical to the serial version.

## Test plan
- Reset: drive reset=0 mid-activity → all outputs 0 immediately. Release, then idle 3 cycles → valid_out stays 0.
- ADD: aluin1=0x7FFFFFFF, aluin2=0x00000001 → next cycle aluout=0x80000000, overflow=1, carry=0, one valid_out pulse.
- SUB: aluin1=5, aluin2=7 → aluout=0xFFFFFFFE, carry=1, overflow=0. Then HADD with 0x0000FFFF+0x00000001 → aluout=0x00000000, carry=1, overflow=0.
- Shift right arithmetic: aluin1=0x80000000, shift_number=4, operation=011 → aluout=0xF8000000, carry/overflow unchanged.
  - Serial: busy high 4 cycles, valid_out on the 4th edge after acceptance; a second request during busy is ignored.
  - Non-serial: result after 1 edge.
- Reset mid-shift: start a shift with shift_number=20, assert reset at cycle 5 → busy=0 and aluout=0 at once. After release, a shift with shift_number=0 and aluin1=0x1234 → aluout=0x1234 next edge.
- Memory read and collision:
  - opselect=101, aluin2=0xDEADBEEF, operation=010 → aluout=0xDEADBEEF, flags 0.
  - Simultaneous enable_arith (AND 0xF0F0F0F0 & 0xFF00FF00) and enable_shift → aluout=0xF000F000, no shift performed.
